line_rotation_scheduler: RTL and testbench
==========================================

// Module: line_rotation_scheduler
// PURPOSE
//  Sequences the line rotator: produces one pseudo-random cut position per active video line from a keyed 32-bit LFSR.
//  Sits between sync_parser (H/V/F) and line_rotator (raw_cut_position); the descrambler runs an identical instance with the same seed.
//  Also counts fields and exposes a one-cycle strobe when a new cut position takes effect.
// PARAMETERS
//  LFSR_WIDTH       32            keystream register width
//  LFSR_TAPS        32'h80200003  Galois feedback mask (x^32+x^22+x^2+x+1)
//  STEPS_PER_LINE   8             LFSR shifts per active line (>= CUT_WIDTH)
//  CUT_WIDTH        8             width of cut_position
//  FIELD_CNT_WIDTH  16            width of field_count
// PORTS
//  clk           in   1    pixel clock (27 MHz BT.656 byte clock)
//  reset         in   1    asynchronous, active-high reset
//  enable        in   1    1 = scramble; 0 = publish cut 0 (identity rotation)
//  seed_load     in   1    one-cycle pulse: capture seed, restart keystream
//  seed          in   32   key / initial LFSR value
//  H             in   1    from sync_parser, high during horizontal blanking
//  V             in   1    from sync_parser, high during vertical blanking
//  F             in   1    from sync_parser, field bit (monitoring only)
//  cut_position  out  8    to line_rotator raw_cut_position; held between strobes
//  cut_strobe    out  1    one-cycle pulse when cut_position updates
//  field_count   out  16   fields started since reset/seed_load, wraps
//  busy          out  1    high while FSM is in STEP or PUBLISH
// BEHAVIOUR
//  Reset: cut_position=0, cut_strobe=0, field_count=0, busy=0, lfsr=32'h1, seed_reg=32'h1, FSM=WAIT_H, prev_H=prev_V=1.
//  Edge detect: h_rise = H & !prev_H; v_fall = !V & prev_V; prev_* registered every cycle.
//  FSM WAIT_H: on h_rise && !V -> STEP, step_cnt=0. h_rise with V=1 ignored (no LFSR advance in blanking).
//  FSM STEP: one Galois step per cycle: lsb=s[0]; s=(s>>1)^(lsb?LFSR_TAPS:0); after STEPS_PER_LINE steps -> PUBLISH.
//  FSM PUBLISH (1 cycle): cut_position <= enable ? lfsr[7:0] : 0; cut_strobe=1; -> WAIT_H.
//  Latency: h_rise sampled in cycle n -> STEP n+1..n+8 -> cut_strobe high in cycle n+9 exactly; value stable until next strobe.
//  enable=0 still advances the LFSR (keeps scrambler/descrambler lock-step); only the published value is zeroed.
//  h_rise during STEP/PUBLISH: ignored (line is 1716 cycles, cannot occur in spec-compliant video).
//  v_fall: field_count <= field_count+1 (wraps at 2^16); same cycle as h_rise -> both honoured.
//  seed_load: seed_reg<=seed; lfsr<=(seed==0)?1:seed; field_count<=0; FSM->WAIT_H (aborts STEP, no strobe);
//   cut_position retained; seed_load wins over v_fall and h_rise in the same cycle.
//  All-zero LFSR state is never loaded: any zero load value is replaced by 32'h1.
//  Reset asserted mid-STEP: immediate return to reset values; no partial strobe.
// CONFIGURATION
//  LINE_ROT_FIELD_RESEED_EN defined: on v_fall lfsr <= reseed(seed_reg ^ {16'h0, field_count_next}), zero->1;
//   keystream restarts per field, so a dropped line desyncs only one field. If STEP active, reseed wins, FSM->WAIT_H.
//  Not defined: LFSR free-runs across fields; v_fall only increments field_count.
// STRUCTURE
//  Package line_rot_pkg: FSM state enum (WAIT_H, STEP, PUBLISH), LFSR_TAPS default, CUT_WIDTH, lfsr_next() function,
//   zero-substitution constant 32'h1; shared with the descrambler-side scheduler and the bench model.
//  Sub-module line_rot_lfsr: LFSR register with load/step/hold controls and zero substitution; FSM and counters stay here.
// TESTING
//  1 seed_load seed=32'h1, enable=1, one active line (V=0, H 0->1) -> cut_strobe 9 cycles later, cut_position=8'h02, lfsr=32'hDB36C002.
//  2 seed_load seed=0 -> behaves identically to seed=1 (first cut 8'h02); LFSR never reaches 0 over 10 frames.
//  3 H rises with V=1 (blanking lines) -> no cut_strobe, lfsr unchanged; first active line after v_fall gets next value.
//  4 enable=0 for two lines then 1 -> cut_position 0,0 then third keystream value (matches reference model with no skipped steps).
//  5 seed_load pulsed 3 cycles after h_rise -> no strobe for that line, field_count=0, next line yields first keystream value.
//  6 Macro on: 3 fields seed=32'hA5A5_0000 -> each field's first cut equals model of seed^field_count; macro off -> continuous stream;
//    reset asserted mid-STEP -> all outputs 0 next cycle.

Source files
------------

// File: rtl/line_rot_pkg.sv
`default_nettype none
// ============================================================================
// Package     : line_rot_pkg
// Description : Shared definitions for the line rotation scheduler and its
//               descrambler-side twin: scheduler FSM states, default keystream
//               polynomial, cut width, zero-substitution value and a single
//               Galois LFSR step function.
// Revision    : 1.0 - initial release
// ============================================================================
package line_rot_pkg;

  localparam int          LFSR_W            = 32;
  localparam logic [31:0] LFSR_TAPS_DEFAULT = 32'h8020_0003; // x^32+x^22+x^2+x+1
  localparam int          CUT_W             = 8;
  // An all-zero Galois LFSR is a lock-up state; any zero load becomes this.
  localparam logic [31:0] LFSR_ZERO_SUB     = 32'h0000_0001;

  typedef enum logic [1:0] {
    ST_WAIT_H  = 2'd0,
    ST_STEP    = 2'd1,
    ST_PUBLISH = 2'd2
  } sched_state_e;

  // One right-shifting Galois step: the bit shifted out decides whether the
  // tap mask is folded back in.
  function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] s,
                                                  input logic [LFSR_W-1:0] taps);
    return (s >> 1) ^ (s[0] ? taps : '0);
  endfunction

endpackage
`default_nettype wire

// File: rtl/line_rot_lfsr.sv
`default_nettype none
// ============================================================================
// Module      : line_rot_lfsr
// Description : Keystream register. Load has priority over step; a zero load
//               value is replaced so the register can never lock up at zero.
// Ports       : clk_i, reset_i    clock / async active-high reset (-> 1)
//               load_i, load_val_i load request and value (zero-substituted)
//               step_i             advance one Galois step
//               state_o            current register value
//               next_o             value after one step from current state
// Revision    : 1.0 - initial release
// ============================================================================
module line_rot_lfsr
  import line_rot_pkg::*;
#(
  parameter int               WIDTH = LFSR_W,
  parameter logic [WIDTH-1:0] TAPS  = LFSR_TAPS_DEFAULT
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             load_i,
  input  logic [WIDTH-1:0] load_val_i,
  input  logic             step_i,
  output logic [WIDTH-1:0] state_o,
  output logic [WIDTH-1:0] next_o
);

  localparam logic [WIDTH-1:0] ONE = WIDTH'(LFSR_ZERO_SUB);

  logic [WIDTH-1:0] lfsr_q;
  logic [WIDTH-1:0] lfsr_d;
  logic [WIDTH-1:0] step_val;
  logic [WIDTH-1:0] load_safe;

  assign step_val  = (lfsr_q >> 1) ^ (lfsr_q[0] ? TAPS : '0);
  assign load_safe = (load_val_i == '0) ? ONE : load_val_i;

  always_comb begin
    lfsr_d = lfsr_q;
    if (load_i) begin
      lfsr_d = load_safe;
    end else if (step_i) begin
      lfsr_d = step_val;
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      lfsr_q <= ONE;
    end else begin
      lfsr_q <= lfsr_d;
    end
  end

  assign state_o = lfsr_q;
  assign next_o  = step_val;

endmodule
`default_nettype wire

// File: rtl/line_rotation_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : line_rotation_scheduler
// Description : Produces one pseudo-random cut position per active video line
//               from a keyed LFSR, counts fields and strobes each new cut.
// Ports       : clk_i, reset_i        pixel clock / async active-high reset
//               enable_i              1 = publish keystream, 0 = publish 0
//               seed_load_i, seed_i   capture key and restart keystream
//               h_i, v_i, f_i         sync flags from the parser (f_i unused)
//               cut_position_o        held cut position for the rotator
//               cut_strobe_o          one-cycle pulse with each new cut
//               field_count_o         fields since reset/seed load (wraps)
//               busy_o                high while stepping or publishing
// Config      : LINE_ROT_FIELD_RESEED_EN - restart keystream on every field
//               from seed ^ field_count; otherwise the LFSR free-runs.
// Revision    : 1.0 - initial release
// ============================================================================
module line_rotation_scheduler
  import line_rot_pkg::*;
#(
  parameter int                    LFSR_WIDTH      = LFSR_W,
  parameter logic [LFSR_WIDTH-1:0] LFSR_TAPS       = LFSR_TAPS_DEFAULT,
  parameter int                    STEPS_PER_LINE  = 8,
  parameter int                    CUT_WIDTH       = CUT_W,
  parameter int                    FIELD_CNT_WIDTH = 16
) (
  input  logic                       clk_i,
  input  logic                       reset_i,
  input  logic                       enable_i,
  input  logic                       seed_load_i,
  input  logic [LFSR_WIDTH-1:0]      seed_i,
  input  logic                       h_i,
  input  logic                       v_i,
  input  logic                       f_i,
  output logic [CUT_WIDTH-1:0]       cut_position_o,
  output logic                       cut_strobe_o,
  output logic [FIELD_CNT_WIDTH-1:0] field_count_o,
  output logic                       busy_o
);

  localparam int                CNT_W     = $clog2(STEPS_PER_LINE + 1);
  localparam logic [CNT_W-1:0]  LAST_STEP = CNT_W'(STEPS_PER_LINE - 1);

  sched_state_e                 state_q, state_d;
  logic [CNT_W-1:0]             step_cnt_q, step_cnt_d;
  logic [CUT_WIDTH-1:0]         cut_position_q, cut_position_d;
  logic [FIELD_CNT_WIDTH-1:0]   field_count_q, field_count_d;
  logic [LFSR_WIDTH-1:0]        seed_reg_q, seed_reg_d;
  logic                         prev_h_q, prev_v_q;

  logic                         h_rise;
  logic                         v_fall;
  logic [FIELD_CNT_WIDTH-1:0]   field_count_next;
  logic                         lfsr_load;
  logic [LFSR_WIDTH-1:0]        lfsr_load_val;
  logic                         lfsr_step;
  logic [LFSR_WIDTH-1:0]        lfsr_state;
  logic [LFSR_WIDTH-1:0]        lfsr_next_val;
  logic                         cut_strobe;
  logic                         busy;

  assign h_rise           = h_i & ~prev_h_q;
  assign v_fall           = ~v_i & prev_v_q;
  assign field_count_next = field_count_q + FIELD_CNT_WIDTH'(1);

  line_rot_lfsr #(
    .WIDTH (LFSR_WIDTH),
    .TAPS  (LFSR_TAPS)
  ) u_lfsr (
    .clk_i      (clk_i),
    .reset_i    (reset_i),
    .load_i     (lfsr_load),
    .load_val_i (lfsr_load_val),
    .step_i     (lfsr_step),
    .state_o    (lfsr_state),
    .next_o     (lfsr_next_val)
  );

  always_comb begin
    state_d        = state_q;
    step_cnt_d     = step_cnt_q;
    cut_position_d = cut_position_q;
    field_count_d  = field_count_q;
    seed_reg_d     = seed_reg_q;
    lfsr_load      = 1'b0;
    lfsr_load_val  = seed_reg_q;
    lfsr_step      = 1'b0;
    cut_strobe     = 1'b0;
    busy           = 1'b0;

    if (v_fall) begin
      field_count_d = field_count_next;
    end

    unique case (state_q)
      ST_WAIT_H: begin
        // Rising H inside vertical blanking is not an active line.
        if (h_rise && !v_i) begin
          state_d    = ST_STEP;
          step_cnt_d = '0;
        end
      end
      ST_STEP: begin
        busy       = 1'b1;
        lfsr_step  = 1'b1;
        step_cnt_d = step_cnt_q + CNT_W'(1);
        if (step_cnt_q == LAST_STEP) begin
          state_d        = ST_PUBLISH;
          // Capture from the final step's result so the new cut is already
          // on the output in the cycle the strobe is high.
          cut_position_d = enable_i ? lfsr_next_val[CUT_WIDTH-1:0] : '0;
        end
      end
      ST_PUBLISH: begin
        busy       = 1'b1;
        cut_strobe = 1'b1;
        state_d    = ST_WAIT_H;
      end
      default: begin
        state_d = ST_WAIT_H;
      end
    endcase

`ifdef LINE_ROT_FIELD_RESEED_EN
    // Per-field keystream restart; a line in progress is abandoned.
    if (v_fall) begin
      lfsr_load      = 1'b1;
      lfsr_load_val  = seed_reg_q ^ LFSR_WIDTH'(field_count_next);
      lfsr_step      = 1'b0;
      cut_position_d = cut_position_q;
      if (state_q != ST_WAIT_H) begin
        state_d = ST_WAIT_H;
      end
    end
`endif

    // Seed load overrides everything else this cycle.
    if (seed_load_i) begin
      seed_reg_d     = seed_i;
      lfsr_load      = 1'b1;
      lfsr_load_val  = seed_i;
      lfsr_step      = 1'b0;
      field_count_d  = '0;
      cut_position_d = cut_position_q;
      state_d        = ST_WAIT_H;
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q        <= ST_WAIT_H;
      step_cnt_q     <= '0;
      cut_position_q <= '0;
      field_count_q  <= '0;
      seed_reg_q     <= LFSR_WIDTH'(LFSR_ZERO_SUB);
      prev_h_q       <= 1'b1;
      prev_v_q       <= 1'b1;
    end else begin
      state_q        <= state_d;
      step_cnt_q     <= step_cnt_d;
      cut_position_q <= cut_position_d;
      field_count_q  <= field_count_d;
      seed_reg_q     <= seed_reg_d;
      prev_h_q       <= h_i;
      prev_v_q       <= v_i;
    end
  end

  assign cut_position_o = cut_position_q;
  assign cut_strobe_o   = cut_strobe;
  assign field_count_o  = field_count_q;
  assign busy_o         = busy;

  // Field bit is carried for monitoring only; the LFSR's upper bits and
  // (without per-field reseed) the stored key are not consumed here.
  logic unused_bits;
`ifdef LINE_ROT_FIELD_RESEED_EN
  assign unused_bits = ^{f_i, lfsr_state, lfsr_next_val[LFSR_WIDTH-1:CUT_WIDTH]};
`else
  assign unused_bits = ^{f_i, lfsr_state, lfsr_next_val[LFSR_WIDTH-1:CUT_WIDTH], seed_reg_q};
`endif

endmodule
`default_nettype wire

// File: tb/tb_line_rotation_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : tb_line_rotation_scheduler
// Description : Directed self-checking bench for line_rotation_scheduler.
//               Keeps a small keystream model (seed, LFSR, field count) to
//               predict each published cut. Honours LINE_ROT_FIELD_RESEED_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_line_rotation_scheduler;

  localparam logic [31:0] TAPS = 32'h8020_0003;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        enable = 1'b1;
  logic        seed_load = 1'b0;
  logic [31:0] seed = 32'h0;
  logic        h = 1'b0;
  logic        v = 1'b0;
  logic        f = 1'b0;
  logic [7:0]  cut_position;
  logic        cut_strobe;
  logic [15:0] field_count;
  logic        busy;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state
  logic [31:0] m_seed  = 32'h1;
  logic [31:0] m_lfsr  = 32'h1;
  logic [15:0] m_field = 16'h0;

  line_rotation_scheduler dut (
    .clk_i          (clk),
    .reset_i        (reset),
    .enable_i       (enable),
    .seed_load_i    (seed_load),
    .seed_i         (seed),
    .h_i            (h),
    .v_i            (v),
    .f_i            (f),
    .cut_position_o (cut_position),
    .cut_strobe_o   (cut_strobe),
    .field_count_o  (field_count),
    .busy_o         (busy)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ---------------- model ----------------
  task automatic m_load(input logic [31:0] s);
    m_seed  = s;
    m_lfsr  = (s == 32'h0) ? 32'h1 : s;
    m_field = 16'h0;
  endtask

  task automatic m_vfall();
    m_field = m_field + 16'h1;
`ifdef LINE_ROT_FIELD_RESEED_EN
    m_lfsr = m_seed ^ {16'h0, m_field};
    if (m_lfsr == 32'h0) m_lfsr = 32'h1;
`endif
  endtask

  task automatic m_line(output logic [7:0] c);
    for (int k = 0; k < 8; k++) begin
      if (m_lfsr[0]) m_lfsr = (m_lfsr >> 1) ^ TAPS;
      else           m_lfsr = m_lfsr >> 1;
    end
    c = enable ? m_lfsr[7:0] : 8'h00;
  endtask

  // ---------------- stimulus ----------------
  task automatic load_seed(input logic [31:0] s);
    seed      = s;
    seed_load = 1'b1;
    tick();
    seed_load = 1'b0;
    m_load(s);
  endtask

  task automatic do_vfall();
    v = 1'b1;
    tick();
    v = 1'b0;
    tick();
    m_vfall();
  endtask

  // Raise H once, then watch 16 cycles for strobe latency, width and busy.
  task automatic run_line(output int lat, output logic [7:0] cut,
                          output int nstb, output int nbusy);
    h = 1'b0;
    tick();
    tick();
    h     = 1'b1;
    lat   = -1;
    cut   = cut_position;
    nstb  = 0;
    nbusy = 0;
    for (int i = 1; i <= 16; i++) begin
      tick();
      if (cut_strobe) begin
        nstb++;
        if (lat < 0) begin
          lat = i;
          cut = cut_position;
        end
      end
      if (busy) nbusy++;
    end
    h = 1'b0;
    tick();
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    reset = 1'b1;
    tick();
    tick();
    n_checks++; if (cut_position !== 8'h00) begin n_fail++; $display("FAIL reset_cut: got %h want 00", cut_position); end
    n_checks++; if (cut_strobe !== 1'b0) begin n_fail++; $display("FAIL reset_strobe: got %b want 0", cut_strobe); end
    n_checks++; if (field_count !== 16'h0) begin n_fail++; $display("FAIL reset_field: got %h want 0000", field_count); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
    reset = 1'b0;
    tick();
    m_vfall(); // prev_V resets high, so V low after release is a field start
    n_checks++; if (field_count !== 16'h1) begin n_fail++; $display("FAIL reset_release_field: got %h want 0001", field_count); end
  endtask

  task automatic test_first_cut();
    int lat, nstb, nbusy; logic [7:0] c, e;
    load_seed(32'h1);
    n_checks++; if (field_count !== 16'h0) begin n_fail++; $display("FAIL seed_field_clear: got %h want 0000", field_count); end
    run_line(lat, c, nstb, nbusy);
    m_line(e);
    n_checks++; if (lat !== 9) begin n_fail++; $display("FAIL first_latency: got %0d want 9", lat); end
    n_checks++; if (c !== 8'h02) begin n_fail++; $display("FAIL first_cut: got %h want 02", c); end
    n_checks++; if (m_lfsr !== 32'hDB36C002) begin n_fail++; $display("FAIL model_lfsr: got %h want DB36C002", m_lfsr); end
    n_checks++; if (nstb !== 1) begin n_fail++; $display("FAIL strobe_width: got %0d want 1", nstb); end
    n_checks++; if (nbusy !== 9) begin n_fail++; $display("FAIL busy_cycles: got %0d want 9", nbusy); end
    n_checks++; if (cut_position !== 8'h02) begin n_fail++; $display("FAIL cut_hold: got %h want 02", cut_position); end
    run_line(lat, c, nstb, nbusy);
    m_line(e);
    n_checks++; if (c !== e) begin n_fail++; $display("FAIL second_cut: got %h want %h", c, e); end
  endtask

  task automatic test_zero_seed();
    int lat, nstb, nbusy; logic [7:0] c, e;
    load_seed(32'h0);
    run_line(lat, c, nstb, nbusy);
    m_line(e);
    n_checks++; if (c !== 8'h02) begin n_fail++; $display("FAIL zero_seed_cut: got %h want 02", c); end
    for (int l = 0; l < 3; l++) begin
      run_line(lat, c, nstb, nbusy);
      m_line(e);
      n_checks++; if (c !== e || lat !== 9) begin n_fail++; $display("FAIL zero_seed_line%0d: got %h lat %0d want %h lat 9", l, c, lat, e); end
    end
  endtask

  task automatic test_blanking();
    int lat, nstb, nbusy; logic [7:0] c, e, held;
    held = cut_position;
    v = 1'b1;
    tick();
    for (int l = 0; l < 3; l++) begin
      run_line(lat, c, nstb, nbusy);
      n_checks++; if (nstb !== 0 || nbusy !== 0) begin n_fail++; $display("FAIL blank_line%0d: strobes %0d busy %0d want 0 0", l, nstb, nbusy); end
    end
    n_checks++; if (cut_position !== held) begin n_fail++; $display("FAIL blank_hold: got %h want %h", cut_position, held); end
    v = 1'b0;
    tick();
    m_vfall();
    n_checks++; if (field_count !== m_field) begin n_fail++; $display("FAIL blank_field: got %h want %h", field_count, m_field); end
    run_line(lat, c, nstb, nbusy);
    m_line(e);
    n_checks++; if (c !== e) begin n_fail++; $display("FAIL after_blank_cut: got %h want %h", c, e); end
  endtask

  task automatic test_enable();
    int lat, nstb, nbusy; logic [7:0] c, e;
    load_seed(32'hC0FF_EE11);
    enable = 1'b0;
    for (int l = 0; l < 2; l++) begin
      run_line(lat, c, nstb, nbusy);
      m_line(e);
      n_checks++; if (c !== 8'h00 || nstb !== 1) begin n_fail++; $display("FAIL disabled_line%0d: got %h strobes %0d want 00 1", l, c, nstb); end
    end
    enable = 1'b1;
    run_line(lat, c, nstb, nbusy);
    m_line(e);
    n_checks++; if (c !== e) begin n_fail++; $display("FAIL reenable_cut: got %h want %h", c, e); end
  endtask

  task automatic test_seed_abort();
    int lat, nstb, nbusy; logic [7:0] c, e, held;
    load_seed(32'h1234_5678);
    do_vfall();
    run_line(lat, c, nstb, nbusy);
    m_line(e);
    held = c;
    h = 1'b0;
    tick();
    tick();
    h = 1'b1;
    tick();
    tick();
    tick();
    seed      = 32'h0BAD_F00D;
    seed_load = 1'b1;
    tick();
    seed_load = 1'b0;
    h         = 1'b0;
    m_load(32'h0BAD_F00D);
    nstb = 0;
    for (int i = 0; i < 15; i++) begin
      tick();
      if (cut_strobe) nstb++;
    end
    n_checks++; if (nstb !== 0) begin n_fail++; $display("FAIL abort_strobe: got %0d want 0", nstb); end
    n_checks++; if (field_count !== 16'h0) begin n_fail++; $display("FAIL abort_field: got %h want 0000", field_count); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL abort_busy: got %b want 0", busy); end
    n_checks++; if (cut_position !== held) begin n_fail++; $display("FAIL abort_cut_hold: got %h want %h", cut_position, held); end
    run_line(lat, c, nstb, nbusy);
    m_line(e);
    n_checks++; if (c !== e) begin n_fail++; $display("FAIL abort_next_cut: got %h want %h", c, e); end
  endtask

  task automatic test_fields();
    int lat, nstb, nbusy; logic [7:0] c, e;
    load_seed(32'hA5A5_0000);
    for (int fi = 1; fi <= 3; fi++) begin
      do_vfall();
      n_checks++; if (field_count !== 16'(fi)) begin n_fail++; $display("FAIL field%0d_count: got %h want %h", fi, field_count, 16'(fi)); end
      run_line(lat, c, nstb, nbusy);
      m_line(e);
      n_checks++; if (c !== e) begin n_fail++; $display("FAIL field%0d_cut: got %h want %h", fi, c, e); end
      run_line(lat, c, nstb, nbusy);
      m_line(e);
      n_checks++; if (c !== e) begin n_fail++; $display("FAIL field%0d_cut2: got %h want %h", fi, c, e); end
    end
  endtask

  task automatic test_reset_mid_step();
    int lat, nstb, nbusy; logic [7:0] c, e;
    h = 1'b0;
    tick();
    tick();
    h = 1'b1;
    tick();
    tick();
    tick();
    tick();
    #2 reset = 1'b1;
    #1;
    n_checks++; if (busy !== 1'b0 || cut_strobe !== 1'b0) begin n_fail++; $display("FAIL midreset_busy_strobe: got %b %b want 0 0", busy, cut_strobe); end
    n_checks++; if (cut_position !== 8'h00 || field_count !== 16'h0) begin n_fail++; $display("FAIL midreset_outputs: got %h %h want 00 0000", cut_position, field_count); end
    tick();
    h = 1'b0;
    reset = 1'b0;
    m_seed  = 32'h1;
    m_lfsr  = 32'h1;
    m_field = 16'h0;
    tick();
    m_vfall();
    n_checks++; if (cut_strobe !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL midreset_no_strobe: got %b %b want 0 0", cut_strobe, busy); end
    run_line(lat, c, nstb, nbusy);
    m_line(e);
    n_checks++; if (c !== 8'h02 || c !== e) begin n_fail++; $display("FAIL midreset_first_cut: got %h want 02 (model %h)", c, e); end
  endtask

  initial begin
    test_reset();
    test_first_cut();
    test_zero_seed();
    test_blanking();
    test_enable();
    test_seed_abort();
    test_fields();
    test_reset_mid_step();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
